output_device_hub: RTL and testbench
====================================

# output_device_hub

Responder for the output-device write port that the writeback stage drives (`output_is_write`, `io_device_id`, `output_devices_value`). It latches writes to the low device ids into parallel device registers (LEDs, seven-segment, etc.). It queues writes to the console id in a small FIFO, which drains over a valid/ready byte interface toward the display side. It reports back-pressure and lost writes so software and the bench can observe overflow.

## Interface
Parameters:
- `NUM_REGS`, 4: number of 32-bit device registers, mapped at ids 0..NUM_REGS-1 (1..16).
- `CONSOLE_ID`, 8'h10: device id of the console FIFO; must be ≥ NUM_REGS.
- `FIFO_DEPTH`, 4: console FIFO entries; power of two, 2..16.

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `output_is_write`  in  1  write strobe from the writeback stage; one write per cycle it is high.
- `io_device_id`  in  8  target device id.
- `output_devices_value`  in  32  write data.
- `dev_regs`  out  32*NUM_REGS  flattened device registers; register k is at bits [32k+31:32k].
- `console_data`  out  8  head byte of the console FIFO.
- `console_valid`  out  1  FIFO non-empty.
- `console_ready`  in  1  sink accepts `console_data` this cycle.
- `io_stall`  out  1  console FIFO full.
- `fifo_level`  out  5  current FIFO occupancy, 0..FIFO_DEPTH.
- `write_ack`  out  1  one-cycle pulse the cycle after a write is accepted.
- `dropped_count`  out  8  saturating count of writes that were not accepted.

## Operation
- Reset (reset_n low, asynchronous): `dev_regs` = 0; FIFO empty (`fifo_level` = 0, `console_valid` = 0, `io_stall` = 0); `console_data` = 0; `write_ack` = 0; `dropped_count` = 0.
- Write decode occurs when `output_is_write` = 1 at a clock edge:
  - Id < NUM_REGS: register[id] ← `output_devices_value`. Accepted.
  - Id == CONSOLE_ID and FIFO not full at the start of the cycle: push `output_devices_value[7:0]`. Upper 24 bits are discarded. Accepted.
  - Id == CONSOLE_ID and FIFO full: not accepted. FIFO contents unchanged. `dropped_count` increments.
  - Any other id: not accepted. `dropped_count` increments.
- `dropped_count` saturates at 255 and never wraps.
- Accepted writes set `write_ack` = 1 for exactly the next cycle. A rejected write leaves `write_ack` low.
- Console FIFO is show-ahead:
  - `console_data` is the head entry whenever `console_valid` = 1, and holds its last value when the FIFO is empty.
  - A pop occurs when `console_valid` and `console_ready` are both high at an edge.
- Pointers are log2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH. Full/empty are derived from `fifo_level`, not from pointer equality.
- Push and pop in the same cycle:
  - FIFO not full: both happen and the level is unchanged.
  - FIFO full: pop happens, push is rejected and counted as dropped. Full is evaluated before the pop.
- Empty FIFO with `console_ready` high: no pop, and `console_data` holds.
- `io_stall` = (`fifo_level` == FIFO_DEPTH). It is combinational from registered state, so it is glitch-free within a cycle.
- Reset asserted mid-stream: the FIFO is flushed and queued bytes are lost. Device registers clear.

## Timing
- Register write: the new value is visible on `dev_regs` 1 cycle after the strobe edge.
- Console path: a byte pushed at edge N gives `console_valid` = 1 with that byte on `console_data` after edge N. This is 1-cycle latency into an empty FIFO.
- Sustained throughput: 1 push and 1 pop per cycle.
- `console_data` and `console_valid` must remain stable while `console_valid` = 1 and `console_ready` = 0.
- `io_stall`, `fifo_level` and `dropped_count` update at the same edge as the push or pop that changes them.
- `write_ack` is high for the cycle following the accepting edge. Back-to-back accepted writes keep it high continuously.

## Test plan
- Reset, then write id 2 with value 99 → `dev_regs[95:64]` = 99 next cycle, other registers 0, `write_ack` pulses once, `dropped_count` = 0.
- With `console_ready` = 0, write id 8'h10 with values 0x141, 0x42, 0x43, 0x44, then 0x45 → level climbs to 4, `io_stall` = 1, fifth write rejected, `dropped_count` = 1, `console_data` = 0x41.
- Raise `console_ready` and hold it → bytes 0x41, 0x42, 0x43, 0x44 appear on consecutive cycles, then `console_valid` = 0, level 0, `io_stall` = 0.
- FIFO full with push of 0x55 and `console_ready` = 1 in the same cycle → head popped, 0x55 dropped, level 3, `dropped_count` increments.
- Write unmapped id 8'h07 300 times → `dropped_count` saturates at 255, `dev_regs` unchanged, `write_ack` never asserts.
- Queue 3 bytes, then pulse `reset_n` low between clock edges → immediate `console_valid` = 0, level 0, all `dev_regs` 0. After reset, a write to id 0 with value 7 works normally.

Source files
------------

// File: rtl/output_device_hub_if.sv
// Output-device write port plus console byte stream, bundled for the hub.
// Latency: none; this file only carries wires.
// Backpressure: console_ready from the sink stalls the console stream; the write port has none.
//
// Signals:
//   output_is_write / io_device_id / output_devices_value : writeback-stage write strobe, target id, data
//   console_data / console_valid / console_ready          : show-ahead console byte stream toward the display
interface output_device_hub_if;
    logic        output_is_write;
    logic [7:0]  io_device_id;
    logic [31:0] output_devices_value;
    logic [7:0]  console_data;
    logic        console_valid;
    logic        console_ready;

    // Writeback stage and display sink side.
    modport master (
        output output_is_write,
        output io_device_id,
        output output_devices_value,
        output console_ready,
        input  console_data,
        input  console_valid
    );

    // Hub side.
    modport slave (
        input  output_is_write,
        input  io_device_id,
        input  output_devices_value,
        input  console_ready,
        output console_data,
        output console_valid
    );
endinterface

// File: rtl/output_device_hub.sv
// Output-device hub: register writes to low ids, console writes queued in a show-ahead byte FIFO.
// Latency: 1 cycle from write strobe to dev_regs / console_valid / write_ack.
// Backpressure: console full raises io_stall; writes arriving then (or to unmapped ids) are dropped and counted.
//
// Ports:
//   clk, reset_n   : clock, asynchronous active-low reset
//   bus (slave)    : write port in, console byte stream out (valid/ready)
//   dev_regs       : flattened device registers, register k at [32k+31:32k]
//   io_stall       : console FIFO full
//   fifo_level     : console FIFO occupancy, 0..FIFO_DEPTH
//   write_ack      : one-cycle pulse after each accepted write
//   dropped_count  : saturating count of rejected writes
module output_device_hub #(
    parameter int         NUM_REGS   = 4,
    parameter logic [7:0] CONSOLE_ID = 8'h10,
    parameter int         FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    output_device_hub_if.slave      bus,
    output logic [32*NUM_REGS-1:0]  dev_regs,
    output logic                    io_stall,
    output logic [4:0]              fifo_level,
    output logic                    write_ack,
    output logic [7:0]              dropped_count
);
    localparam int         PW          = $clog2(FIFO_DEPTH);
    localparam logic [7:0] NUM_REGS_ID = 8'(NUM_REGS);
    localparam logic [4:0] DEPTH_LVL   = 5'(FIFO_DEPTH);

    logic [NUM_REGS-1:0][31:0]  regs_q;
    logic [FIFO_DEPTH-1:0][7:0] mem_q;
    logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [4:0]                 level_q, level_d;
    logic [7:0]                 hold_q;
    logic [7:0]                 dropped_q, dropped_d;
    logic                       ack_q;

    logic full, empty, is_reg, is_con, push, pop, accept, drop;

    always_comb begin
        // Full/empty come from the occupancy count, so pointer aliasing never matters.
        full   = (level_q == DEPTH_LVL);
        empty  = (level_q == 5'd0);
        is_reg = bus.output_is_write && (bus.io_device_id < NUM_REGS_ID);
        is_con = bus.output_is_write && (bus.io_device_id == CONSOLE_ID);
        // Full is judged before any same-cycle pop: a push into a full FIFO is lost even if the head leaves.
        push   = is_con && !full;
        pop    = !empty && bus.console_ready;
        accept = is_reg || push;
        drop   = bus.output_is_write && !accept;

        level_d = level_q;
        if (push && !pop) begin
            level_d = level_q + 5'd1;
        end else if (pop && !push) begin
            level_d = level_q - 5'd1;
        end

        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
        dropped_d = (drop && (dropped_q != 8'hFF)) ? dropped_q + 8'd1 : dropped_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q    <= '0;
            mem_q     <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            hold_q    <= '0;
            dropped_q <= '0;
            ack_q     <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (is_reg && (bus.io_device_id == 8'(k))) begin
                    regs_q[k] <= bus.output_devices_value;
                end
            end
            if (push) begin
                mem_q[wr_ptr_q] <= bus.output_devices_value[7:0];
            end
            // Remember the byte leaving the head so console_data holds it once the FIFO drains.
            if (pop) begin
                hold_q <= mem_q[rd_ptr_q];
            end
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            dropped_q <= dropped_d;
            ack_q     <= accept;
        end
    end

    assign dev_regs          = regs_q;
    assign bus.console_valid = !empty;
    assign bus.console_data  = empty ? hold_q : mem_q[rd_ptr_q];
    assign io_stall          = full;
    assign fifo_level        = level_q;
    assign write_ack         = ack_q;
    assign dropped_count     = dropped_q;
endmodule

// File: tb/tb_output_device_hub.sv
// Bench for output_device_hub: directed writes, console bytes checked through a scoreboard queue.
// Latency: expects 1-cycle register/console/ack latency.
// Backpressure: exercises console_ready low/high, full FIFO, drop saturation and mid-stream reset.
module tb_output_device_hub;
    logic        clk;
    logic        reset_n;
    logic [127:0] dev_regs;
    logic        io_stall;
    logic [4:0]  fifo_level;
    logic        write_ack;
    logic [7:0]  dropped_count;

    int n_cmp;
    int n_err;
    int ack_seen;
    logic [7:0] sb[$];
    logic [7:0] sb_exp;

    output_device_hub_if bus ();

    output_device_hub #(
        .NUM_REGS   (4),
        .CONSOLE_ID (8'h10),
        .FIFO_DEPTH (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .bus           (bus),
        .dev_regs      (dev_regs),
        .io_stall      (io_stall),
        .fifo_level    (fifo_level),
        .write_ack     (write_ack),
        .dropped_count (dropped_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_write(input logic [7:0] id, input logic [31:0] val);
        bus.output_is_write      = 1'b1;
        bus.io_device_id         = id;
        bus.output_devices_value = val;
    endtask

    task automatic clr_write();
        bus.output_is_write      = 1'b0;
        bus.io_device_id         = 8'h00;
        bus.output_devices_value = 32'h0;
    endtask

    task automatic chk_regs(input string tag, input logic [31:0] r0, input logic [31:0] r1,
                            input logic [31:0] r2, input logic [31:0] r3);
        chk({tag, "_r0"}, dev_regs[31:0],   r0);
        chk({tag, "_r1"}, dev_regs[63:32],  r1);
        chk({tag, "_r2"}, dev_regs[95:64],  r2);
        chk({tag, "_r3"}, dev_regs[127:96], r3);
    endtask

    // Every pop is checked against the oldest byte the bench expects to have been queued.
    always @(negedge clk) begin
        if (reset_n && bus.console_valid && bus.console_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                sb_exp = sb.pop_front();
                chk("console_pop", {24'h0, bus.console_data}, {24'h0, sb_exp});
            end
        end
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        ack_seen = 0;
        reset_n  = 1'b0;
        bus.console_ready = 1'b0;
        clr_write();

        #12;
        chk_regs("rst", 0, 0, 0, 0);
        chk("rst_valid", {31'h0, bus.console_valid}, 0);
        chk("rst_level", {27'h0, fifo_level}, 0);
        chk("rst_stall", {31'h0, io_stall}, 0);
        chk("rst_data", {24'h0, bus.console_data}, 0);
        chk("rst_ack", {31'h0, write_ack}, 0);
        chk("rst_drop", {24'h0, dropped_count}, 0);
        tick();
        reset_n = 1'b1;
        tick();

        // Register write.
        set_write(8'd2, 32'd99);
        tick();
        clr_write();
        chk_regs("reg_wr", 0, 0, 99, 0);
        chk("reg_ack", {31'h0, write_ack}, 1);
        chk("reg_drop", {24'h0, dropped_count}, 0);
        tick();
        chk("reg_ack_off", {31'h0, write_ack}, 0);

        // Fill the console FIFO with the sink stalled; upper bits of the first value are discarded.
        for (int i = 0; i < 4; i++) begin
            set_write(8'h10, (i == 0) ? 32'h141 : 32'h41 + 32'(i));
            sb.push_back(8'h41 + 8'(i));
            tick();
            chk("fill_level", {27'h0, fifo_level}, 32'(i + 1));
            chk("fill_ack", {31'h0, write_ack}, 1);
            chk("fill_head", {24'h0, bus.console_data}, 32'h41);
        end
        chk("fill_stall", {31'h0, io_stall}, 1);
        set_write(8'h10, 32'h45);
        tick();
        clr_write();
        chk("ovf_level", {27'h0, fifo_level}, 4);
        chk("ovf_drop", {24'h0, dropped_count}, 1);
        chk("ovf_ack", {31'h0, write_ack}, 0);
        chk("ovf_head", {24'h0, bus.console_data}, 32'h41);

        // Drain.
        bus.console_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        chk("drain_valid", {31'h0, bus.console_valid}, 0);
        chk("drain_level", {27'h0, fifo_level}, 0);
        chk("drain_stall", {31'h0, io_stall}, 0);
        chk("drain_sb", 32'(sb.size()), 0);
        tick();
        chk("empty_hold", {24'h0, bus.console_data}, 32'h44);
        chk("empty_valid", {31'h0, bus.console_valid}, 0);

        // Streaming: one push and one pop per cycle keeps the level at 1.
        for (int i = 0; i < 5; i++) begin
            set_write(8'h10, 32'h60 + 32'(i));
            sb.push_back(8'h60 + 8'(i));
            tick();
            chk("stream_level", {27'h0, fifo_level}, 1);
            chk("stream_ack", {31'h0, write_ack}, 1);
        end
        clr_write();
        tick();
        chk("stream_empty", {27'h0, fifo_level}, 0);

        // Push into a full FIFO while popping: the pop happens, the push is lost.
        bus.console_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            set_write(8'h10, 32'h50 + 32'(i));
            sb.push_back(8'h50 + 8'(i));
            tick();
        end
        set_write(8'h10, 32'h55);
        bus.console_ready = 1'b1;
        tick();
        clr_write();
        chk("fullpp_level", {27'h0, fifo_level}, 3);
        chk("fullpp_drop", {24'h0, dropped_count}, 2);
        chk("fullpp_ack", {31'h0, write_ack}, 0);
        for (int i = 0; i < 3; i++) tick();
        chk("fullpp_drain", {27'h0, fifo_level}, 0);
        chk("fullpp_sb", 32'(sb.size()), 0);

        // Unmapped id hammering: counter saturates, nothing else moves.
        bus.console_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            set_write(8'h07, 32'hDEAD0000 + 32'(i));
            tick();
            if (write_ack) ack_seen++;
        end
        clr_write();
        chk("sat_drop", {24'h0, dropped_count}, 255);
        chk("sat_ack_seen", 32'(ack_seen), 0);
        chk_regs("sat", 0, 0, 99, 0);

        // Mid-stream asynchronous reset.
        for (int i = 0; i < 3; i++) begin
            set_write(8'h10, 32'h71 + 32'(i));
            sb.push_back(8'h71 + 8'(i));
            tick();
        end
        clr_write();
        chk("pre_rst_level", {27'h0, fifo_level}, 3);
        #2;
        reset_n = 1'b0;
        #1;
        sb.delete();
        chk("arst_valid", {31'h0, bus.console_valid}, 0);
        chk("arst_level", {27'h0, fifo_level}, 0);
        chk("arst_drop", {24'h0, dropped_count}, 0);
        chk_regs("arst", 0, 0, 0, 0);
        #3;
        reset_n = 1'b1;
        tick();
        set_write(8'd0, 32'd7);
        tick();
        clr_write();
        chk_regs("post_rst", 7, 0, 0, 0);
        chk("post_rst_ack", {31'h0, write_ack}, 1);
        tick();
        chk("end_sb", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
